// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and byte-lane helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Half uses only off[1] and word ignores off, so natural alignment falls out for free.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_BYTE ? 4'b0001 << off :
               size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_HALF ? off[0] : size[1] ? |off : 1'b0;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        return size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
               size == SZ_HALF ? {{16{~uns & h[15]}}, h} : word;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: word-organised RAM with per-byte write enables and a registered read port.
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder with programmable wait latency and sized loads.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses via resp_err instead of aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int COLS        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [COLS-1:0] addr2Mem,
    input  logic [COLS-1:0] data2Mem,
    output logic [COLS-1:0] dataFromMem,
    output logic            resp_valid,
    output logic            resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(WAIT_CYCLES + 2);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            we_q, uns_q, ready_q, valid_q, err_q;
    logic [1:0]      size_q;
    logic [AW+1:0]   addr_q, addr_d;
    logic [COLS-1:0] data_q, dout_q;
    logic [31:0]     rdata, wdata;
    logic [3:0]      be;
    logic            accept, err;
    logic            unused_addr;

    assign accept      = ready_q & req_valid;
    assign unused_addr = ^addr2Mem[COLS-1:AW+2];
    // Read address tracks the request being accepted so a zero-wait access still sees its word.
    assign addr_d      = accept ? addr2Mem[AW+1:0] : addr_q;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign err = misaligned(size_q, addr_q[1:0]);
`else
    assign err = 1'b0;
`endif

    assign be    = (state_q == RESP && we_q && !err) ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;
    assign wdata = size_q == SZ_BYTE ? {4{data_q[7:0]}} :
                   size_q == SZ_HALF ? {2{data_q[15:0]}} : data_q;

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk     (clk),
        .we_i    (be),
        .addr_i  (addr_d[AW+1:2]),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    we_q    <= req_we;
                    uns_q   <= req_unsigned;
                    size_q  <= req_size;
                    addr_q  <= addr_d;
                    data_q  <= data2Mem;
                    cnt_q   <= CW'(WAIT_CYCLES);
                    ready_q <= 1'b0;
                    state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_q <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b1;
                    err_q   <= err;
                    if (!we_q) dout_q <= err ? '0 : load_extend(rdata, size_q, addr_q[1:0], uns_q);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign resp_valid  = valid_q;
    assign resp_err    = err_q;
    assign dataFromMem = dout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks against a byte-array memory model.
module tb_dmem_responder;

    localparam int WC = 2;
    localparam int DEPTH = 1024;
    localparam int NB = DEPTH * 4;

    logic        clk = 0, rst = 0, req_valid = 0, req_we = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] addr2Mem = 0, data2Mem = 0, dataFromMem;
    logic        req_ready, resp_valid, resp_err;

    int          n_checks = 0, n_fail = 0, cyc = 0, resp_cnt = 0, r0 = 0, n = 0;
    int          acc [4];
    logic [7:0]  mem [NB];
    logic [31:0] last_load = 0, got, w20, w40;
    logic [31:0] bd [4];

    dmem_responder #(.COLS(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .addr2Mem     (addr2Mem),
        .data2Mem     (data2Mem),
        .dataFromMem  (dataFromMem),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (resp_valid) resp_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic mis(input logic [31:0] a, input logic [1:0] sz);
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic int eaddr(input logic [31:0] a, input logic [1:0] sz);
        int e;
        e = int'(a % NB);
        return e - e % nbytes(sz);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int nb, e;
        logic [31:0] v;
        nb = nbytes(sz);
        e = eaddr(a, sz);
        v = 0;
        for (int k = 0; k < nb; k++) v |= 32'(mem[e + k]) << (8 * k);
        if (!uns && nb < 4 && v[8 * nb - 1]) v |= 32'hFFFF_FFFF << (8 * nb);
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int e;
        e = eaddr(a, sz);
        for (int k = 0; k < nbytes(sz); k++) mem[e + k] = 8'(d >> (8 * k));
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] res);
        logic trap;
        logic [31:0] exp_d;
        int w, lat;
        trap = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = mis(a, sz);
`endif
        exp_d = we ? last_load : (trap ? 32'h0 : ref_load(a, sz, uns));
        @(negedge clk);
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; addr2Mem = a; data2Mem = d;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        check("ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 0; req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        addr2Mem = $urandom; data2Mem = $urandom;
        lat = 0;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("latency", lat, WC + 1);
        check("err", 32'(resp_err), 32'(trap));
        check(we ? "st_hold" : "ld_data", dataFromMem, exp_d);
        res = dataFromMem;
        if (!we) last_load = exp_d;
        if (we && !trap) ref_store(a, sz, d);
        @(posedge clk); #1;
        check("pulse", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_data", dataFromMem, 32'd0);
        @(negedge clk) rst = 1;

        for (int i = 0; i < 64; i++) xact(1, 2'd2, 0, 32'(i * 4), $urandom, got);

        xact(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, got);
        xact(0, 2'd2, 0, 32'h10, 0, got);
        check("plan_word", got, 32'hDEAD_BEEF);
        xact(1, 2'd0, 0, 32'h13, 32'h80, got);
        xact(0, 2'd0, 0, 32'h13, 0, got);
        check("plan_sbyte", got, 32'hFFFF_FF80);
        xact(0, 2'd0, 1, 32'h13, 0, got);
        check("plan_ubyte", got, 32'h0000_0080);
        xact(0, 2'd2, 0, 32'h10, 0, got);
        check("plan_merge", got, 32'h80AD_BEEF);

        xact(0, 2'd2, 0, 32'h20, 0, w20);
        xact(1, 2'd1, 0, 32'h22, 32'h1234, got);
        xact(0, 2'd1, 0, 32'h22, 0, got);
        check("plan_half", got, 32'h0000_1234);
        xact(0, 2'd2, 0, 32'h20, 0, got);
        check("plan_lanes", got, {16'h1234, w20[15:0]});

        xact(0, 2'd2, 0, 32'h1010, 0, got);
        check("plan_alias", got, 32'h80AD_BEEF);

        xact(0, 2'd2, 0, 32'h40, 0, w40);
        xact(0, 2'd2, 0, 32'h42, 0, got);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("plan_misalign", got, 32'h0);
`else
        check("plan_misalign", got, w40);
`endif

        r0 = resp_cnt;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'd2; req_unsigned = 0;
        for (int i = 0; i < 4; i++) begin
            bd[i] = $urandom;
            addr2Mem = 32'h80 + 32'(4 * i);
            data2Mem = bd[i];
            n = 0;
            while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
            if (i > 0) check("b2b_busy", n, 3);
            @(posedge clk); #1;
            acc[i] = cyc;
            if (i > 0) check("b2b_gap", acc[i] - acc[i - 1], 4);
            ref_store(32'h80 + 32'(4 * i), 2'd2, bd[i]);
        end
        req_valid = 0;
        repeat (6) @(posedge clk);
        #1;
        check("b2b_resps", resp_cnt - r0, 4);
        for (int i = 0; i < 4; i++) begin
            xact(0, 2'd2, 0, 32'h80 + 32'(4 * i), 0, got);
            check("b2b_rd", got, bd[i]);
        end

        xact(1, 2'd2, 0, 32'h40, 32'h1122_3344, got);
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'd2; addr2Mem = 32'h40; data2Mem = 32'hCAFE_BABE;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        r0 = resp_cnt;
        rst = 0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1;
        last_load = 0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_noresp", resp_cnt - r0, 0);
        check("mid_rst_ready2", 32'(req_ready), 32'd1);
        check("mid_rst_data", dataFromMem, 32'd0);
        xact(0, 2'd2, 0, 32'h40, 0, got);
        check("mid_rst_keep", got, 32'h1122_3344);

        for (int i = 0; i < 80; i++)
            xact(1'($urandom), 2'($urandom), 1'($urandom),
                 ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255)), $urandom, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
